// File: rtl/i2c_target_regs.sv
// I2C target with register-pointer addressing, multi-byte write/read and address NACK.
// Build option: define I2C_TARGET_AUTOINC_EN to auto-increment the pointer after each byte.
module i2c_target_regs #(
    parameter logic [6:0] BASE_ADDR   = 7'b1000000,
    parameter int         ADDR_PINS   = 6,
    parameter int         PTR_W       = 8,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [ADDR_PINS-1:0] addr_pins_i,
    input  logic                 scl_i,
    input  logic                 sda_i,
    output logic                 sda_oe_o,
    output logic                 reg_wr_o,
    output logic [PTR_W-1:0]     reg_addr_o,
    output logic [7:0]           reg_wdata_o,
    input  logic [7:0]           reg_rdata_i,
    output logic                 busy_o
);

`ifdef I2C_TARGET_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR,
        S_W_ACK,
        S_PTR,
        S_WDATA,
        S_R_ADDR_ACK,
        S_RDATA,
        S_R_MACK,
        S_IGNORE
    } state_t;

    state_t                 r_state;
    state_t                 r_next;
    logic [7:0]             r_shift;
    logic [3:0]             r_bit_cnt;
    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_d;
    logic                   r_sda_d;

    logic                   w_scl;
    logic                   w_sda;
    logic                   w_start;
    logic                   w_stop;
    logic                   w_rise;
    logic                   w_fall;
    logic [6:0]             w_my_addr;
    logic [PTR_W-1:0]       w_ptr_load;

    // Idle bus is high on both lines, so the synchronisers reset to 1.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_d    <= 1'b1;
            r_sda_d    <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_i};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_i};
            r_scl_d    <= r_scl_sync[SYNC_STAGES-1];
            r_sda_d    <= r_sda_sync[SYNC_STAGES-1];
        end
    end

    assign w_scl   = r_scl_sync[SYNC_STAGES-1];
    assign w_sda   = r_sda_sync[SYNC_STAGES-1];
    assign w_start = w_scl & r_scl_d & r_sda_d & ~w_sda;
    assign w_stop  = w_scl & r_scl_d & ~r_sda_d & w_sda;
    assign w_rise  = w_scl & ~r_scl_d;
    assign w_fall  = ~w_scl & r_scl_d;

    generate
        if (ADDR_PINS >= 7) begin : g_addr_all_pins
            assign w_my_addr = addr_pins_i[6:0];
        end else begin : g_addr_mixed
            assign w_my_addr = {BASE_ADDR[6:ADDR_PINS], addr_pins_i};
        end

        if (PTR_W <= 8) begin : g_ptr_narrow
            assign w_ptr_load = r_shift[PTR_W-1:0];
        end else begin : g_ptr_wide
            assign w_ptr_load = {{(PTR_W-8){1'b0}}, r_shift};
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= S_IDLE;
            r_next      <= S_PTR;
            r_shift     <= 8'h00;
            r_bit_cnt   <= 4'd0;
            sda_oe_o    <= 1'b0;
            reg_wr_o    <= 1'b0;
            reg_addr_o  <= '0;
            reg_wdata_o <= 8'h00;
            busy_o      <= 1'b0;
        end else begin
            reg_wr_o <= 1'b0;
            if (AUTOINC && reg_wr_o) begin
                reg_addr_o <= reg_addr_o + PTR_W'(1);
            end

            if (w_stop) begin
                r_state   <= S_IDLE;
                r_bit_cnt <= 4'd0;
                sda_oe_o  <= 1'b0;
                busy_o    <= 1'b0;
            end else if (w_start) begin
                // Repeated start keeps the pointer so a read can follow a pointer write.
                r_state   <= S_ADDR;
                r_bit_cnt <= 4'd0;
                sda_oe_o  <= 1'b0;
                busy_o    <= 1'b1;
            end else begin
                case (r_state)
                    S_ADDR, S_PTR, S_WDATA: begin
                        if (w_rise) begin
                            r_shift   <= {r_shift[6:0], w_sda};
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end else if (w_fall && r_bit_cnt == 4'd8) begin
                            r_bit_cnt <= 4'd0;
                            if (r_state == S_ADDR) begin
                                if (r_shift[7:1] == w_my_addr) begin
                                    sda_oe_o <= 1'b1;
                                    r_next   <= S_PTR;
                                    r_state  <= r_shift[0] ? S_R_ADDR_ACK : S_W_ACK;
                                end else begin
                                    r_state <= S_IGNORE;
                                    busy_o  <= 1'b0;
                                end
                            end else if (r_state == S_PTR) begin
                                reg_addr_o <= w_ptr_load;
                                sda_oe_o   <= 1'b1;
                                r_next     <= S_WDATA;
                                r_state    <= S_W_ACK;
                            end else begin
                                reg_wdata_o <= r_shift;
                                reg_wr_o    <= 1'b1;
                                sda_oe_o    <= 1'b1;
                                r_next      <= S_WDATA;
                                r_state     <= S_W_ACK;
                            end
                        end
                    end
                    S_W_ACK: begin
                        if (w_fall) begin
                            sda_oe_o  <= 1'b0;
                            r_bit_cnt <= 4'd0;
                            r_state   <= r_next;
                        end
                    end
                    S_R_ADDR_ACK: begin
                        if (w_fall) begin
                            r_shift   <= reg_rdata_i;
                            sda_oe_o  <= ~reg_rdata_i[7];
                            r_bit_cnt <= 4'd1;
                            r_state   <= S_RDATA;
                        end
                    end
                    S_RDATA: begin
                        // r_bit_cnt counts bits already presented on SDA.
                        if (w_fall) begin
                            if (r_bit_cnt == 4'd8) begin
                                sda_oe_o  <= 1'b0;
                                r_bit_cnt <= 4'd0;
                                r_state   <= S_R_MACK;
                            end else begin
                                sda_oe_o  <= ~r_shift[6];
                                r_shift   <= {r_shift[6:0], 1'b0};
                                r_bit_cnt <= r_bit_cnt + 4'd1;
                            end
                        end
                    end
                    S_R_MACK: begin
                        if (w_rise) begin
                            if (w_sda) begin
                                r_state <= S_IGNORE;
                                busy_o  <= 1'b0;
                            end else if (AUTOINC) begin
                                reg_addr_o <= reg_addr_o + PTR_W'(1);
                            end
                        end else if (w_fall) begin
                            r_shift   <= reg_rdata_i;
                            sda_oe_o  <= ~reg_rdata_i[7];
                            r_bit_cnt <= 4'd1;
                            r_state   <= S_RDATA;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target_regs.sv
// Directed bench for i2c_target_regs: bit-banged I2C master with a reg[n]=n bank.
// Expected values follow I2C_TARGET_AUTOINC_EN when it is defined for the build.
module tb_i2c_target_regs;

`ifdef I2C_TARGET_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] straps = 6'h00;
    logic       scl = 1'b1;
    logic       m_sda_low = 1'b0;
    logic       sda_bus;
    logic       sda_oe;
    logic       reg_wr;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic [7:0] reg_rdata;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] wr_addr_q[$];
    logic [7:0] wr_data_q[$];
    int         wr_width = 0;
    int         max_wr_width = 0;
    bit         oe_seen = 1'b0;

    assign sda_bus   = !(m_sda_low || sda_oe);
    assign reg_rdata = reg_addr;

    always #5 clk = ~clk;

    i2c_target_regs dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .addr_pins_i (straps),
        .scl_i       (scl),
        .sda_i       (sda_bus),
        .sda_oe_o    (sda_oe),
        .reg_wr_o    (reg_wr),
        .reg_addr_o  (reg_addr),
        .reg_wdata_o (reg_wdata),
        .reg_rdata_i (reg_rdata),
        .busy_o      (busy)
    );

    always @(negedge clk) begin
        if (reg_wr) begin
            wr_addr_q.push_back(reg_addr);
            wr_data_q.push_back(reg_wdata);
            wr_width = wr_width + 1;
            if (wr_width > max_wr_width) max_wr_width = wr_width;
            $display("reg write: addr=%02h data=%02h", reg_addr, reg_wdata);
        end else begin
            wr_width = 0;
        end
        if (sda_oe) oe_seen = 1'b1;
    end

    task automatic wait_q();
        repeat (10) @(negedge clk);
    endtask

    task automatic xfer_bit(input bit b, output bit s);
        m_sda_low = ~b;
        wait_q();
        scl = 1'b1;
        wait_q();
        s = sda_bus;
        wait_q();
        scl = 1'b0;
        wait_q();
    endtask

    task automatic i2c_start();
        m_sda_low = 1'b0;
        wait_q();
        scl = 1'b1;
        wait_q();
        m_sda_low = 1'b1;
        wait_q();
        scl = 1'b0;
        wait_q();
    endtask

    task automatic i2c_stop();
        m_sda_low = 1'b1;
        wait_q();
        scl = 1'b1;
        wait_q();
        m_sda_low = 1'b0;
        wait_q();
        wait_q();
    endtask

    task automatic write_byte(input logic [7:0] d, output bit ack_n);
        bit s;
        for (int i = 7; i >= 0; i--) xfer_bit(d[i], s);
        xfer_bit(1'b1, ack_n);
        $display("master wrote %02h, target ack_n=%0b", d, ack_n);
    endtask

    task automatic read_byte(input bit mack_n, output logic [7:0] d);
        bit s;
        for (int i = 7; i >= 0; i--) begin
            xfer_bit(1'b1, s);
            d[i] = s;
        end
        xfer_bit(mack_n, s);
        $display("master read %02h, master ack_n=%0b", d, mack_n);
    endtask

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
        max_wr_width = 0;
        oe_seen = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        n_cmp++; if (sda_oe !== 1'b0) begin n_err++; $display("FAIL rst_sda_oe: got %0b expected 0", sda_oe); end
        n_cmp++; if (reg_wr !== 1'b0) begin n_err++; $display("FAIL rst_reg_wr: got %0b expected 0", reg_wr); end
        n_cmp++; if (reg_addr !== 8'h00) begin n_err++; $display("FAIL rst_reg_addr: got %02h expected 00", reg_addr); end
        n_cmp++; if (reg_wdata !== 8'h00) begin n_err++; $display("FAIL rst_reg_wdata: got %02h expected 00", reg_wdata); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %0b expected 0", busy); end
        rst_n = 1'b1;
        wait_q();
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL post_rst_busy: got %0b expected 0", busy); end
        $display("reset sequence done");
    endtask

    task automatic test_write();
        bit a0, a1, a2, a3;
        clear_log();
        straps = 6'h00;
        i2c_start();
        write_byte(8'h80, a0);
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL wr_busy: got %0b expected 1", busy); end
        write_byte(8'h06, a1);
        write_byte(8'hAA, a2);
        write_byte(8'h55, a3);
        i2c_stop();
        n_cmp++; if ({a0, a1, a2, a3} !== 4'b0000) begin n_err++; $display("FAIL wr_acks: got %b expected 0000", {a0, a1, a2, a3}); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL wr_busy_stop: got %0b expected 0", busy); end
        n_cmp++; if (wr_addr_q.size() != 2) begin n_err++; $display("FAIL wr_count: got %0d expected 2", wr_addr_q.size()); end
        n_cmp++; if (wr_addr_q[0] !== 8'h06 || wr_data_q[0] !== 8'hAA) begin n_err++; $display("FAIL wr_first: got %02h/%02h expected 06/AA", wr_addr_q[0], wr_data_q[0]); end
        n_cmp++; if (wr_addr_q[1] !== (AUTOINC ? 8'h07 : 8'h06) || wr_data_q[1] !== 8'h55) begin n_err++; $display("FAIL wr_second: got %02h/%02h expected %02h/55", wr_addr_q[1], wr_data_q[1], AUTOINC ? 8'h07 : 8'h06); end
        n_cmp++; if (reg_addr !== (AUTOINC ? 8'h08 : 8'h06)) begin n_err++; $display("FAIL wr_final_ptr: got %02h expected %02h", reg_addr, AUTOINC ? 8'h08 : 8'h06); end
        n_cmp++; if (max_wr_width != 1) begin n_err++; $display("FAIL wr_pulse_width: got %0d expected 1", max_wr_width); end
    endtask

    task automatic test_nack_addr();
        bit a0, a1;
        clear_log();
        straps = 6'h01;
        i2c_start();
        write_byte(8'h80, a0);
        n_cmp++; if (a0 !== 1'b1) begin n_err++; $display("FAIL nack_addr_ack: got %0b expected 1", a0); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL nack_busy: got %0b expected 0", busy); end
        write_byte(8'h06, a1);
        n_cmp++; if (a1 !== 1'b1) begin n_err++; $display("FAIL nack_data_ack: got %0b expected 1", a1); end
        i2c_stop();
        n_cmp++; if (oe_seen !== 1'b0) begin n_err++; $display("FAIL nack_sda_driven: got %0b expected 0", oe_seen); end
        n_cmp++; if (wr_addr_q.size() != 0) begin n_err++; $display("FAIL nack_writes: got %0d expected 0", wr_addr_q.size()); end
        straps = 6'h00;
    endtask

    task automatic test_wrap();
        bit a0, a1, a2, a3;
        clear_log();
        i2c_start();
        write_byte(8'h80, a0);
        write_byte(8'hFF, a1);
        write_byte(8'h11, a2);
        write_byte(8'h22, a3);
        i2c_stop();
        n_cmp++; if ({a0, a1, a2, a3} !== 4'b0000) begin n_err++; $display("FAIL wrap_acks: got %b expected 0000", {a0, a1, a2, a3}); end
        n_cmp++; if (wr_addr_q.size() != 2) begin n_err++; $display("FAIL wrap_count: got %0d expected 2", wr_addr_q.size()); end
        n_cmp++; if (wr_addr_q[0] !== 8'hFF || wr_data_q[0] !== 8'h11) begin n_err++; $display("FAIL wrap_first: got %02h/%02h expected FF/11", wr_addr_q[0], wr_data_q[0]); end
        n_cmp++; if (wr_addr_q[1] !== (AUTOINC ? 8'h00 : 8'hFF) || wr_data_q[1] !== 8'h22) begin n_err++; $display("FAIL wrap_second: got %02h/%02h expected %02h/22", wr_addr_q[1], wr_data_q[1], AUTOINC ? 8'h00 : 8'hFF); end
    endtask

    task automatic test_read();
        bit a0, a1, a2;
        logic [7:0] d0, d1, d2;
        clear_log();
        i2c_start();
        write_byte(8'h80, a0);
        write_byte(8'h10, a1);
        i2c_start();
        write_byte(8'h81, a2);
        n_cmp++; if ({a0, a1, a2} !== 3'b000) begin n_err++; $display("FAIL rd_acks: got %b expected 000", {a0, a1, a2}); end
        read_byte(1'b0, d0);
        read_byte(1'b0, d1);
        read_byte(1'b1, d2);
        n_cmp++; if (d0 !== 8'h10) begin n_err++; $display("FAIL rd_byte0: got %02h expected 10", d0); end
        n_cmp++; if (d1 !== (AUTOINC ? 8'h11 : 8'h10)) begin n_err++; $display("FAIL rd_byte1: got %02h expected %02h", d1, AUTOINC ? 8'h11 : 8'h10); end
        n_cmp++; if (d2 !== (AUTOINC ? 8'h12 : 8'h10)) begin n_err++; $display("FAIL rd_byte2: got %02h expected %02h", d2, AUTOINC ? 8'h12 : 8'h10); end
        n_cmp++; if (sda_oe !== 1'b0) begin n_err++; $display("FAIL rd_release: got %0b expected 0", sda_oe); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rd_busy_nack: got %0b expected 0", busy); end
        i2c_stop();
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rd_busy_stop: got %0b expected 0", busy); end
        n_cmp++; if (wr_addr_q.size() != 0) begin n_err++; $display("FAIL rd_writes: got %0d expected 0", wr_addr_q.size()); end
    endtask

    task automatic test_reset_mid();
        bit a0, a1, a2, a3, s;
        logic [7:0] d;
        d = 8'hA5;
        clear_log();
        i2c_start();
        write_byte(8'h80, a0);
        write_byte(8'h06, a1);
        for (int i = 7; i >= 5; i--) xfer_bit(d[i], s);
        m_sda_low = ~d[4];
        wait_q();
        scl = 1'b1;
        wait_q();
        n_cmp++; if (reg_addr !== 8'h06) begin n_err++; $display("FAIL mid_ptr_before: got %02h expected 06", reg_addr); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (sda_oe !== 1'b0) begin n_err++; $display("FAIL mid_rst_sda_oe: got %0b expected 0", sda_oe); end
        n_cmp++; if (reg_addr !== 8'h00) begin n_err++; $display("FAIL mid_rst_ptr: got %02h expected 00", reg_addr); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_rst_busy: got %0b expected 0", busy); end
        $display("reset asserted mid-byte");
        wait_q();
        rst_n = 1'b1;
        wait_q();
        scl = 1'b0;
        wait_q();
        i2c_stop();
        clear_log();
        i2c_start();
        write_byte(8'h80, a0);
        write_byte(8'h33, a2);
        write_byte(8'h44, a3);
        i2c_stop();
        n_cmp++; if ({a0, a2, a3} !== 3'b000) begin n_err++; $display("FAIL mid_clean_acks: got %b expected 000", {a0, a2, a3}); end
        n_cmp++; if (wr_addr_q.size() != 1 || wr_addr_q[0] !== 8'h33 || wr_data_q[0] !== 8'h44) begin n_err++; $display("FAIL mid_clean_write: got n=%0d %02h/%02h expected n=1 33/44", wr_addr_q.size(), wr_addr_q[0], wr_data_q[0]); end
    endtask

    task automatic test_glitch();
        bit a0, a1, a2, a3, a4, s;
        clear_log();
        i2c_start();
        write_byte(8'h80, a0);
        write_byte(8'h20, a1);
        for (int i = 0; i < 3; i++) xfer_bit(1'b1, s);
        m_sda_low = 1'b1;
        wait_q();
        scl = 1'b1;
        wait_q();
        m_sda_low = 1'b0;
        wait_q();
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL glitch_stop_busy: got %0b expected 0", busy); end
        m_sda_low = 1'b1;
        wait_q();
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL glitch_start_busy: got %0b expected 1", busy); end
        scl = 1'b0;
        wait_q();
        $display("stop/start glitch issued mid-byte");
        write_byte(8'h80, a2);
        write_byte(8'h30, a3);
        write_byte(8'h5A, a4);
        i2c_stop();
        n_cmp++; if ({a0, a1, a2, a3, a4} !== 5'b00000) begin n_err++; $display("FAIL glitch_acks: got %b expected 00000", {a0, a1, a2, a3, a4}); end
        n_cmp++; if (wr_addr_q.size() != 1 || wr_addr_q[0] !== 8'h30 || wr_data_q[0] !== 8'h5A) begin n_err++; $display("FAIL glitch_write: got n=%0d %02h/%02h expected n=1 30/5A", wr_addr_q.size(), wr_addr_q[0], wr_data_q[0]); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_nack_addr();
        test_wrap();
        test_read();
        test_reset_mid();
        test_glitch();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
